// File: rtl/team_03_input_conditioner_if.sv
// Bundles the conditioner's enable, raw pad inputs, clear strobes and
// conditioned outputs. The master side drives inputs; the slave is the conditioner.
interface team_03_input_conditioner_if #(
  parameter int NUM_IN = 4
);
  logic              en;
  logic [NUM_IN-1:0] gpio_in;
  logic [NUM_IN-1:0] clr_pend;
  logic [NUM_IN-1:0] level_out;
  logic [NUM_IN-1:0] rise_pulse;
  logic [NUM_IN-1:0] fall_pulse;
  logic [NUM_IN-1:0] pend;
  logic [NUM_IN-1:0] ovf;
  logic              pend_any;

  modport master (
    output en, gpio_in, clr_pend,
    input  level_out, rise_pulse, fall_pulse, pend, ovf, pend_any
  );

  modport slave (
    input  en, gpio_in, clr_pend,
    output level_out, rise_pulse, fall_pulse, pend, ovf, pend_any
  );
endinterface

// File: rtl/team_03_input_conditioner.sv
// Per-channel GPIO conditioner: two-flop synchronizer, counting debouncer,
// registered edge pulses and sticky pending/overflow flags.
module team_03_input_conditioner #(
  parameter int NUM_IN    = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic nrst,
  team_03_input_conditioner_if.slave io
);

  localparam int                 CNT_W   = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [NUM_IN-1:0] sync_p0;
  logic [NUM_IN-1:0] sync_p1;
  logic [NUM_IN-1:0] stable;
  logic [CNT_W-1:0]  cnt [NUM_IN];
  logic [NUM_IN-1:0] rise_q;
  logic [NUM_IN-1:0] fall_q;
  logic [NUM_IN-1:0] pend_q;
  logic [NUM_IN-1:0] ovf_q;
  logic [NUM_IN-1:0] accept;

  // Stage p0/p1: metastability synchronizer, free-running regardless of en
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= io.gpio_in;
      sync_p1 <= sync_p0;
    end
  end

  // A change is accepted on the edge where the count is already saturated
  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      accept[i] = io.en && (sync_p1[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Stage p2: debounce counter and stable level
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stable <= '0;
      for (int i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!io.en || (sync_p1[i] == stable[i])) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync_p1[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pulses and sticky flags update on the same edge as the stable level;
  // a coincident clear drops the overflow but lets the new event re-arm pend.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rise_q <= '0;
      fall_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      rise_q <= accept & sync_p1;
      fall_q <= accept & ~sync_p1;
      pend_q <= accept | (pend_q & ~io.clr_pend);
      ovf_q  <= ~io.clr_pend & (ovf_q | (accept & pend_q));
    end
  end

  assign io.level_out  = stable;
  assign io.rise_pulse = rise_q;
  assign io.fall_pulse = fall_q;
  assign io.pend       = pend_q;
  assign io.ovf        = ovf_q;
  assign io.pend_any   = |pend_q;

endmodule

// File: tb/tb_team_03_input_conditioner.sv
// Directed bench for team_03_input_conditioner with DB_CYCLES=16: reset,
// latency, glitch rejection, overflow, enable gating and mid-count reset.
module tb_team_03_input_conditioner;

  logic clk;
  logic nrst;
  int   n_tests;
  int   n_fail;
  logic [3:0] rise_seen;
  logic [3:0] fall_seen;

  team_03_input_conditioner_if #(.NUM_IN(4)) io ();

  team_03_input_conditioner #(.NUM_IN(4), .DB_CYCLES(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .io   (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit after it
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      rise_seen = rise_seen | io.rise_pulse;
      fall_seen = fall_seen | io.fall_pulse;
    end
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rise_seen   = '0;
    fall_seen   = '0;
    nrst        = 1'b0;
    io.en       = 1'b0;
    io.gpio_in  = 4'hF;
    io.clr_pend = 4'h0;

    // Reset held with all inputs high
    tick(3);
    chk("rst_level", 32'(io.level_out), 32'h0);
    chk("rst_rise",  32'(io.rise_pulse), 32'h0);
    chk("rst_fall",  32'(io.fall_pulse), 32'h0);
    chk("rst_pend",  32'(io.pend), 32'h0);
    chk("rst_ovf",   32'(io.ovf), 32'h0);
    chk("rst_any",   32'(io.pend_any), 32'h0);

    // Release; first sample on the next edge, level appears 17 edges later
    nrst  = 1'b1;
    io.en = 1'b1;
    tick(17);
    chk("rel_level_early", 32'(io.level_out), 32'h0);
    tick(1);
    chk("rel_level", 32'(io.level_out), 32'hF);
    chk("rel_rise",  32'(io.rise_pulse), 32'hF);
    chk("rel_pend",  32'(io.pend), 32'hF);
    tick(1);
    chk("rel_rise_off", 32'(io.rise_pulse), 32'h0);
    io.clr_pend = 4'hF;
    tick(1);
    io.clr_pend = 4'h0;
    chk("rel_clr_pend", 32'(io.pend), 32'h0);
    chk("rel_clr_any",  32'(io.pend_any), 32'h0);

    // Return to a clean all-low state
    nrst       = 1'b0;
    io.gpio_in = 4'h0;
    #2;
    nrst = 1'b1;
    tick(3);
    chk("clean_level", 32'(io.level_out), 32'h0);

    // Step on channel 0
    io.gpio_in = 4'b0001;
    tick(17);
    chk("step_level_early", 32'(io.level_out), 32'h0);
    chk("step_rise_early",  32'(io.rise_pulse), 32'h0);
    tick(1);
    chk("step_level", 32'(io.level_out), 32'h1);
    chk("step_rise",  32'(io.rise_pulse), 32'h1);
    chk("step_pend",  32'(io.pend), 32'h1);
    chk("step_any",   32'(io.pend_any), 32'h1);
    tick(1);
    chk("step_rise_off", 32'(io.rise_pulse), 32'h0);
    chk("step_pend_hold", 32'(io.pend), 32'h1);

    // Glitch of 10 cycles on channel 1
    rise_seen  = '0;
    io.gpio_in = 4'b0011;
    tick(10);
    io.gpio_in = 4'b0001;
    tick(30);
    chk("glitch_level", 32'(io.level_out[1]), 32'h0);
    chk("glitch_rise",  32'(rise_seen[1]), 32'h0);
    chk("glitch_pend",  32'(io.pend[1]), 32'h0);

    // Overflow on channel 2
    io.clr_pend = 4'hF;
    tick(1);
    io.clr_pend = 4'h0;
    io.gpio_in  = 4'b0101;
    tick(18);
    chk("ovf_rise",     32'(io.rise_pulse), 32'h4);
    chk("ovf_pend_set", 32'(io.pend), 32'h4);
    chk("ovf_ovf_zero", 32'(io.ovf), 32'h0);
    io.gpio_in = 4'b0001;
    tick(18);
    chk("ovf_fall",     32'(io.fall_pulse), 32'h4);
    chk("ovf_both",     32'(io.rise_pulse & io.fall_pulse), 32'h0);
    chk("ovf_set",      32'(io.ovf), 32'h4);
    chk("ovf_pend",     32'(io.pend), 32'h4);
    io.clr_pend = 4'b0100;
    tick(1);
    io.clr_pend = 4'h0;
    chk("ovf_clr_pend", 32'(io.pend), 32'h0);
    chk("ovf_clr_ovf",  32'(io.ovf), 32'h0);
    io.gpio_in = 4'b0101;
    tick(18);
    chk("coin_pend_pre", 32'(io.pend), 32'h4);
    io.gpio_in = 4'b0001;
    tick(17);
    io.clr_pend = 4'b0100;
    tick(1);
    io.clr_pend = 4'h0;
    chk("coin_fall", 32'(io.fall_pulse), 32'h4);
    chk("coin_pend", 32'(io.pend), 32'h4);
    chk("coin_ovf",  32'(io.ovf), 32'h0);

    // Enable gating on channel 3
    io.en      = 1'b0;
    io.gpio_in = 4'b1001;
    rise_seen  = '0;
    tick(50);
    chk("en_off_level", 32'(io.level_out), 32'h1);
    chk("en_off_rise",  32'(rise_seen), 32'h0);
    chk("en_off_pend3", 32'(io.pend[3]), 32'h0);
    io.en = 1'b1;
    tick(15);
    chk("en_on_early", 32'(io.level_out), 32'h1);
    tick(1);
    chk("en_on_level", 32'(io.level_out), 32'h9);
    chk("en_on_rise",  32'(io.rise_pulse), 32'h8);

    // Asynchronous reset with channel 0 mid-count
    io.gpio_in = 4'b1000;
    tick(10);
    nrst = 1'b0;
    #2;
    chk("async_level", 32'(io.level_out), 32'h0);
    chk("async_pend",  32'(io.pend), 32'h0);
    chk("async_any",   32'(io.pend_any), 32'h0);
    io.gpio_in = 4'b0001;
    #2;
    nrst = 1'b1;
    tick(17);
    chk("post_rst_early", 32'(io.level_out), 32'h0);
    tick(1);
    chk("post_rst_level", 32'(io.level_out), 32'h1);
    chk("post_rst_rise",  32'(io.rise_pulse), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/team_03_input_conditioner.md
TEAM_03_INPUT_CONDITIONER -- requirements
Module: team_03_input_conditioner

Interface
REQ-001 SHALL have parameter NUM_IN, default 4: number of conditioned GPIO inputs (the mprj_io[19:16] group).
REQ-002 SHALL have parameter DB_CYCLES, default 16: consecutive stable synchronized cycles required to accept a level change; legal range 2..1024.
REQ-003 SHALL have port clk, input, 1: single system clock; all flops on its rising edge.
REQ-004 SHALL have port nrst, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port en, input, 1: conditioner enable from the team Wishbone wrapper.
REQ-006 SHALL have port gpio_in, input, NUM_IN: raw asynchronous pad inputs.
REQ-007 SHALL have port clr_pend, input, NUM_IN: one-cycle write-1-to-clear for pend and ovf, per channel.
REQ-008 SHALL have port level_out, output, NUM_IN: debounced stable level.
REQ-009 SHALL have port rise_pulse, output, NUM_IN: one-cycle pulse on an accepted 0->1 change.
REQ-010 SHALL have port fall_pulse, output, NUM_IN: one-cycle pulse on an accepted 1->0 change.
REQ-011 SHALL have port pend, output, NUM_IN: sticky event-pending flag.
REQ-012 SHALL have port ovf, output, NUM_IN: sticky flag, event arrived while pend already set.
REQ-013 SHALL have port pend_any, output, 1: combinational OR of pend.

Function
REQ-014 SHALL pass each gpio_in bit through a two-flop synchronizer (s1, s2) that runs regardless of en.
REQ-015 SHALL give each channel a counter of width clog2(DB_CYCLES) and a stable register driving level_out.
REQ-016 Per edge with en=1: s2==stable -> cnt<=0; s2!=stable and cnt<DB_CYCLES-1 -> cnt<=cnt+1; s2!=stable and cnt==DB_CYCLES-1 -> stable<=s2, cnt<=0.
REQ-017 Latency SHALL be exact. Value first sampled into s1 on edge N and held stays out of level_out through edge N+DB_CYCLES. It appears on level_out on edge N+DB_CYCLES+1.
REQ-018 Any cycle with s2==stable during counting SHALL restart the count from 0. Pulses shorter than DB_CYCLES synchronized cycles SHALL never reach level_out.
REQ-019 rise_pulse/fall_pulse SHALL be registered and asserted for exactly the first cycle level_out shows the new value; never both on one channel at once.
REQ-020 With en=0: cnt held at 0, stable held, pulses 0, pend/ovf not set; clr_pend still acts.
REQ-021 After en rises (first sampled high on edge M), a persisting difference SHALL update stable on edge M+DB_CYCLES-1.
REQ-022 pend[i] SHALL set on rise_pulse[i] or fall_pulse[i]. It SHALL clear on clr_pend[i]. When set and clear occur in the same cycle, set wins.
REQ-023 ovf[i] SHALL set when an event occurs while pend[i]=1 and clr_pend[i]=0. It SHALL clear on clr_pend[i]. When clear and event occur in the same cycle, the result is pend=1, ovf=0.
REQ-024 Channels SHALL be fully independent; simultaneous events on several channels SHALL all be recorded in the same cycle.

Reset
REQ-025 nrst low SHALL immediately force s1, s2, stable, cnt, rise_pulse, fall_pulse, pend, ovf to 0, independent of clk.
REQ-026 Reset asserted mid-count SHALL abort the count. After release, a high input SHALL require the full REQ-017 latency again.
REQ-027 Deassertion of nrst is synchronized externally. The block SHALL need no cycles after release before it samples.

Verification
REQ-028 Reset: nrst=0, gpio_in=4'hF, DB_CYCLES=16 -> all outputs 0 during reset. After release and en=1, level_out=4'hF 17 edges after the first sample, with rise_pulse=4'hF for one cycle.
REQ-029 Step: gpio_in[0] 0->1 sampled edge N -> level_out[0]=1 and rise_pulse[0]=1 after edge N+17 only. pend[0]=1 and pend_any=1 from that cycle.
REQ-030 Glitch: gpio_in[1] high for 10 cycles, then low -> level_out[1], rise_pulse[1], pend[1] remain 0.
REQ-031 Overflow: pend[2]=1, then a fall event on channel 2 -> ovf[2]=1. A later clr_pend[2]=1 -> pend[2]=0 and ovf[2]=0 next cycle. A clear coincident with an event -> pend[2]=1, ovf[2]=0.
REQ-032 Enable gating: en=0, gpio_in[3] 0->1 held 50 cycles -> no change. en sampled high edge M -> level_out[3]=1 after edge M+15.
REQ-033 Async reset at cnt=8 on channel 0 -> outputs 0 before next clk edge. After release, full 17-edge latency is required.
